// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-stage stalls, bubbles, flush and MDU start/wait/done sequencing.
// Optional stall performance counters are built when STALL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       ex_mdu_req,
    input  logic       mdu_done,
    input  logic       me_exc,
    output logic [4:0] stall,
    output logic       bubble_ex,
    output logic       bubble_me,
    output logic       flush,
    output logic       mdu_start,
    output logic       mdu_abort,
    output logic       mdu_err,
    output logic [1:0] state
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] perf_lu,
    output logic [31:0] perf_mdu,
    output logic [15:0] perf_exc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [7:0] TO_LAST = 8'(MDU_TIMEOUT - 1);

    fsm_t       cur, nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       lu;
    logic [4:0] stall_c;
    logic       bex_c, bme_c, flush_c, start_c, abort_c, err_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= S_IDLE;
            cnt <= 8'd0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        stall_c = 5'b00000;
        bex_c   = 1'b0;
        bme_c   = 1'b0;
        flush_c = 1'b0;
        start_c = 1'b0;
        abort_c = 1'b0;
        err_c   = 1'b0;
        lu = ex_is_load && (ex_rd != 5'd0) &&
             ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

        case (cur)
            S_IDLE: begin
                if (ex_mdu_req) begin
                    start_c      = 1'b1;
                    stall_c[2:0] = 3'b111;
                    bme_c        = 1'b1;
                    nxt          = S_WAIT;
                    cnt_nxt      = 8'd0;
                end
            end
            S_WAIT: begin
                stall_c[2:0] = 3'b111;
                bme_c        = 1'b1;
                if (mdu_done) begin
                    nxt = S_DONE;
                end else if (cnt == TO_LAST) begin
                    err_c   = 1'b1;
                    abort_c = 1'b1;
                    nxt     = S_DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase

        // Load-use holds IF/ID; the EX bubble is only needed when EX itself is not held.
        if (lu) begin
            stall_c[1:0] = 2'b11;
            bex_c        = !stall_c[2];
        end

        if (me_exc) begin
            flush_c = 1'b1;
            stall_c = 5'b00000;
            bex_c   = 1'b0;
            bme_c   = 1'b0;
            start_c = 1'b0;
            err_c   = 1'b0;
            abort_c = (cur == S_WAIT);
            nxt     = S_IDLE;
            cnt_nxt = 8'd0;
        end
    end

    // Everything is silenced while reset is held.
    assign stall     = rst ? stall_c : 5'b00000;
    assign bubble_ex = rst & bex_c;
    assign bubble_me = rst & bme_c;
    assign flush     = rst & flush_c;
    assign mdu_start = rst & start_c;
    assign mdu_abort = rst & abort_c;
    assign mdu_err   = rst & err_c;
    assign state     = rst ? cur : S_IDLE;

`ifdef STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_lu  <= 32'd0;
            perf_mdu <= 32'd0;
            perf_exc <= 16'd0;
        end else begin
            if (lu && !me_exc) perf_lu  <= perf_lu + 32'd1;
            if (stall_c[2])    perf_mdu <= perf_mdu + 32'd1;
            if (flush_c)       perf_exc <= perf_exc + 16'd1;
        end
    end
`endif

endmodule
